// File: rtl/demux_sec_if.sv
// Bus bundle for demux_sec: producer side (data, select, valid/ready),
// per-channel consumer outputs with acks, and the accepted-word counter.
interface demux_sec_if #(
    parameter int ANCHO = 4
);
    logic [ANCHO-1:0] i_Datos;
    logic [1:0]       i_Sel;
    logic             i_Valido;
    logic             o_Listo;
    logic [ANCHO-1:0] o_Salida_0;
    logic [ANCHO-1:0] o_Salida_1;
    logic [ANCHO-1:0] o_Salida_2;
    logic [ANCHO-1:0] o_Salida_3;
    logic [3:0]       o_Valido;
    logic [3:0]       i_Ack;
    logic [7:0]       o_Cuenta;

    modport master (
        output i_Datos, i_Sel, i_Valido, i_Ack,
        input  o_Listo, o_Salida_0, o_Salida_1, o_Salida_2, o_Salida_3,
               o_Valido, o_Cuenta
    );

    modport slave (
        input  i_Datos, i_Sel, i_Valido, i_Ack,
        output o_Listo, o_Salida_0, o_Salida_1, o_Salida_2, o_Salida_3,
               o_Valido, o_Cuenta
    );
endinterface

// File: rtl/demux_sec.sv
// Sequential 1-to-4 demultiplexer with one-word holding register per channel.
// Optional accepted-word counter enabled by macro DEMUX_SEC_CONTADOR_EN.
module demux_sec #(
    parameter int ANCHO = 4
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    demux_sec_if.slave  bus
);

    logic [ANCHO-1:0] dato_r [4];
    logic [3:0]       lleno_r;
    logic [3:0]       lleno_next_s;
    logic [3:0]       carga_s;
    logic [3:0]       entrega_s;
    logic             listo_s;
    logic             xfer_s;

    // Ready when the addressed channel is empty or is being drained this cycle.
    always_comb begin
        listo_s = 1'b0;
        if (!lleno_r[bus.i_Sel] || bus.i_Ack[bus.i_Sel]) begin
            listo_s = 1'b1;
        end else begin
            listo_s = 1'b0;
        end
    end

    assign xfer_s    = bus.i_Valido & listo_s;
    assign entrega_s = lleno_r & bus.i_Ack;

    // One-hot load strobe for the addressed channel.
    always_comb begin
        carga_s = 4'b0000;
        if (xfer_s) begin
            case (bus.i_Sel)
                2'd0:    carga_s = 4'b0001;
                2'd1:    carga_s = 4'b0010;
                2'd2:    carga_s = 4'b0100;
                2'd3:    carga_s = 4'b1000;
                default: carga_s = 4'b0000;
            endcase
        end else begin
            carga_s = 4'b0000;
        end
    end

    // A load on the same edge as a delivery keeps the channel full (no bubble).
    assign lleno_next_s = (lleno_r & ~entrega_s) | carga_s;

    // Holding registers and full flags; empty channels keep their last word.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            for (int k = 0; k < 4; k++) begin
                dato_r[k] <= {ANCHO{1'b0}};
            end
            lleno_r <= 4'b0000;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (carga_s[k]) begin
                    dato_r[k] <= bus.i_Datos;
                end else begin
                    dato_r[k] <= dato_r[k];
                end
            end
            lleno_r <= lleno_next_s;
        end
    end

    assign bus.o_Listo    = listo_s;
    assign bus.o_Valido   = lleno_r;
    assign bus.o_Salida_0 = dato_r[0];
    assign bus.o_Salida_1 = dato_r[1];
    assign bus.o_Salida_2 = dato_r[2];
    assign bus.o_Salida_3 = dato_r[3];

`ifdef DEMUX_SEC_CONTADOR_EN
    logic [7:0] cuenta_r;

    // Accepted-word counter, wraps naturally at 8 bits.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            cuenta_r <= 8'd0;
        end else if (xfer_s) begin
            cuenta_r <= cuenta_r + 8'd1;
        end else begin
            cuenta_r <= cuenta_r;
        end
    end

    assign bus.o_Cuenta = cuenta_r;
`else
    assign bus.o_Cuenta = 8'd0;
`endif

endmodule

// File: tb/tb_demux_sec.sv
// Directed self-checking bench for demux_sec; expected counter values follow
// whether DEMUX_SEC_CONTADOR_EN is defined for the build.
module tb_demux_sec;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;
    int   n_xfer;

    demux_sec_if #(.ANCHO(4)) bus ();

    demux_sec #(.ANCHO(4)) dut (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt();
`ifdef DEMUX_SEC_CONTADOR_EN
        return 32'(n_xfer % 256);
`else
        return 32'd0;
`endif
    endfunction

    task automatic xfer(input logic [3:0] d, input logic [1:0] s);
        bus.i_Datos  = d;
        bus.i_Sel    = s;
        bus.i_Valido = 1'b1;
        @(posedge clk);
        #1;
        bus.i_Valido = 1'b0;
        n_xfer++;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        n_xfer  = 0;
        rst_n        = 1'b0;
        bus.i_Datos  = 4'h0;
        bus.i_Sel    = 2'd0;
        bus.i_Valido = 1'b0;
        bus.i_Ack    = 4'b0000;
        #12;
        check_val("rst_valido", 32'(bus.o_Valido), 32'h0);
        check_val("rst_sal0", 32'(bus.o_Salida_0), 32'h0);
        check_val("rst_cuenta", 32'(bus.o_Cuenta), 32'h0);
        check_val("rst_listo", 32'(bus.o_Listo), 32'h1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic transfer to channel 2
        xfer(4'hA, 2'd2);
        check_val("t1_sal2", 32'(bus.o_Salida_2), 32'hA);
        check_val("t1_valido", 32'(bus.o_Valido), 32'h4);
        check_val("t1_sal0", 32'(bus.o_Salida_0), 32'h0);
        check_val("t1_sal1", 32'(bus.o_Salida_1), 32'h0);
        check_val("t1_sal3", 32'(bus.o_Salida_3), 32'h0);
        check_val("t1_cuenta", 32'(bus.o_Cuenta), exp_cnt());

        // Full channel 1 blocks only its own transfers
        xfer(4'h3, 2'd1);
        bus.i_Datos  = 4'h7;
        bus.i_Sel    = 2'd1;
        bus.i_Valido = 1'b1;
        #1;
        check_val("blk_listo", 32'(bus.o_Listo), 32'h0);
        @(posedge clk);
        #1;
        check_val("blk_sal1", 32'(bus.o_Salida_1), 32'h3);
        check_val("blk_valido", 32'(bus.o_Valido), 32'h6);
        bus.i_Sel = 2'd3;
        #1;
        check_val("alt_listo", 32'(bus.o_Listo), 32'h1);
        @(posedge clk);
        #1;
        bus.i_Valido = 1'b0;
        n_xfer++;
        check_val("alt_sal3", 32'(bus.o_Salida_3), 32'h7);
        check_val("alt_valido", 32'(bus.o_Valido), 32'hE);
        check_val("alt_cuenta", 32'(bus.o_Cuenta), exp_cnt());

        // Delivery and transfer on the same channel, same edge
        xfer(4'h5, 2'd0);
        check_val("ch0_sal0", 32'(bus.o_Salida_0), 32'h5);
        bus.i_Ack = 4'b0001;
        #1;
        check_val("pass_listo", 32'(bus.o_Listo), 32'h1);
        xfer(4'h6, 2'd0);
        bus.i_Ack = 4'b0000;
        check_val("pass_sal0", 32'(bus.o_Salida_0), 32'h6);
        check_val("pass_valido", 32'(bus.o_Valido), 32'hF);

        // Drain all four at once; values retained
        bus.i_Ack = 4'b1111;
        @(posedge clk);
        #1;
        bus.i_Ack = 4'b0000;
        check_val("drain_valido", 32'(bus.o_Valido), 32'h0);
        check_val("drain_sal0", 32'(bus.o_Salida_0), 32'h6);
        check_val("drain_sal1", 32'(bus.o_Salida_1), 32'h3);
        check_val("drain_sal2", 32'(bus.o_Salida_2), 32'hA);
        check_val("drain_sal3", 32'(bus.o_Salida_3), 32'h7);

        // Ack on empty channels has no effect
        bus.i_Ack = 4'b1111;
        @(posedge clk);
        #1;
        bus.i_Ack = 4'b0000;
        check_val("idle_ack_valido", 32'(bus.o_Valido), 32'h0);
        check_val("idle_ack_sal2", 32'(bus.o_Salida_2), 32'hA);

        // Asynchronous reset mid-cycle
        xfer(4'h9, 2'd0);
        xfer(4'hC, 2'd3);
        check_val("pre_rst_valido", 32'(bus.o_Valido), 32'h9);
        #2;
        rst_n = 1'b0;
        #1;
        n_xfer = 0;
        check_val("arst_valido", 32'(bus.o_Valido), 32'h0);
        check_val("arst_sal0", 32'(bus.o_Salida_0), 32'h0);
        check_val("arst_sal3", 32'(bus.o_Salida_3), 32'h0);
        check_val("arst_listo", 32'(bus.o_Listo), 32'h1);
        bus.i_Datos  = 4'hF;
        bus.i_Sel    = 2'd1;
        bus.i_Valido = 1'b1;
        @(posedge clk);
        #1;
        check_val("inrst_valido", 32'(bus.o_Valido), 32'h0);
        check_val("inrst_cuenta", 32'(bus.o_Cuenta), 32'h0);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.i_Valido = 1'b0;
        n_xfer++;
        check_val("post_rst_valido", 32'(bus.o_Valido), 32'h2);
        check_val("post_rst_sal1", 32'(bus.o_Salida_1), 32'hF);
        check_val("post_rst_cuenta", 32'(bus.o_Cuenta), exp_cnt());

        // 257 back-to-back transfers into channel 2 with continuous ack
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        n_xfer = 0;
        bus.i_Ack    = 4'b0100;
        bus.i_Sel    = 2'd2;
        bus.i_Valido = 1'b1;
        for (int i = 0; i < 257; i++) begin
            bus.i_Datos = 4'(i);
            @(posedge clk);
            #1;
            n_xfer++;
            if (i == 100) begin
                check_val("cnt_mid", 32'(bus.o_Cuenta), exp_cnt());
            end
        end
        bus.i_Valido = 1'b0;
        bus.i_Ack    = 4'b0000;
`ifdef DEMUX_SEC_CONTADOR_EN
        check_val("cnt_wrap", 32'(bus.o_Cuenta), 32'h1);
`else
        check_val("cnt_wrap", 32'(bus.o_Cuenta), 32'h0);
`endif
        check_val("stream_valido", 32'(bus.o_Valido), 32'h4);
        check_val("stream_sal2", 32'(bus.o_Salida_2), 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/demux_sec.md
DEMUX_SEC -- requirements
Module: demux_sec

Interface
REQ-001 Parameter: ANCHO, default 4, data width of every data port in bits.
REQ-002 Port: i_Clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: i_Rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: i_Datos  input  ANCHO  input data word.
REQ-005 Port: i_Sel  input  2  destination channel (0..3) for i_Datos.
REQ-006 Port: i_Valido  input  1  input word present.
REQ-007 Port: o_Listo  output  1  block can accept a word for the channel on i_Sel this cycle.
REQ-008 Ports: o_Salida_0, o_Salida_1, o_Salida_2, o_Salida_3  output  ANCHO each  channel data.
REQ-009 Port: o_Valido  output  4  bit k set means o_Salida_k holds an undelivered word.
REQ-010 Port: i_Ack  input  4  bit k set means the channel-k consumer takes the word this cycle.
REQ-011 Port: o_Cuenta  output  8  accepted-word counter (see Configuration).

Function
REQ-012 Each channel k SHALL have a one-word holding register and a full flag; the full flag drives o_Valido[k].
REQ-013 o_Listo SHALL be combinational: 1 when channel i_Sel is empty, or is full with i_Ack[i_Sel]=1 in the same cycle; otherwise 0.
REQ-014 An input transfer SHALL occur on a rising edge with i_Valido=1 and o_Listo=1; at most one transfer per cycle.
REQ-015 i_Datos and i_Sel SHALL be sampled only on a transfer edge; they are ignored at all other times.
REQ-016 On a transfer to channel k, o_Salida_k SHALL take i_Datos and o_Valido[k] SHALL be 1 from the next cycle (latency 1 cycle).
REQ-017 A delivery on channel k SHALL occur on an edge with o_Valido[k]=1 and i_Ack[k]=1; o_Valido[k] clears after it unless a transfer to k happens on the same edge.
REQ-018 Simultaneous delivery and transfer on the same channel SHALL keep o_Valido[k]=1 and load the new word, so no bubble is inserted.
REQ-019 Deliveries on different channels SHALL be independent and may all occur on the same edge, concurrent with one transfer.
REQ-020 i_Ack[k] while o_Valido[k]=0 SHALL have no effect.
REQ-021 An empty channel SHALL keep its last delivered value on o_Salida_k, so no zeroing after delivery.
REQ-022 A full channel that is not acknowledged SHALL hold o_Salida_k stable and SHALL block only transfers addressed to it.
REQ-023 When i_Valido=1 and o_Listo=0, the producer SHALL hold its word; the block neither drops nor duplicates it.

Reset
REQ-024 While i_Rst_n=0, every o_Salida_k SHALL be 0, o_Valido SHALL be 4'b0000 and o_Cuenta SHALL be 0; this takes effect immediately, independent of i_Clk.
REQ-025 Reset asserted mid-operation SHALL discard all held words; the first transfer SHALL be possible on the first rising edge after i_Rst_n returns to 1.
REQ-026 o_Listo during reset SHALL follow REQ-013 with all channels empty, meaning 1; no transfer occurs while reset is asserted.

Configuration
REQ-027 Macro DEMUX_SEC_CONTADOR_EN defined: o_Cuenta SHALL increment by 1 on every transfer, wrapping from 255 to 0.
REQ-028 Macro DEMUX_SEC_CONTADOR_EN not defined: no counter register is built and o_Cuenta SHALL be constantly 0; all other behaviour is unchanged.

Verification
REQ-029 Reset, then transfer i_Datos=4'hA with i_Sel=2 -> next cycle o_Salida_2=4'hA, o_Valido=4'b0100; other outputs 0.
REQ-030 Channel 1 full with i_Ack[1]=0, then i_Valido=1 with i_Sel=1 -> o_Listo=0 and o_Salida_1 unchanged; the same word with i_Sel=3 -> accepted.
REQ-031 Channel 0 full with 4'h5, then i_Ack[0]=1 together with a transfer of 4'h6 to channel 0 -> next cycle o_Salida_0=4'h6 and o_Valido[0]=1.
REQ-032 All four channels full, then i_Ack=4'b1111 for one cycle -> o_Valido=4'b0000 next cycle and each o_Salida_k retains its value.
REQ-033 Channels 0 and 3 full, then i_Rst_n pulsed low mid-cycle -> o_Valido=0 and outputs 0 immediately, without waiting for a clock edge.
REQ-034 With DEMUX_SEC_CONTADOR_EN defined, 257 transfers -> o_Cuenta=1; without the macro, the same stimulus -> o_Cuenta=0 throughout.
